mem_arbiter_rr: RTL
===================

// Module: mem_arbiter_rr
// PURPOSE
//   Parametrised N-client arbiter in front of the single-port graphics BRAM. Sits between the
//   data fetching engine (client 0), the rectangle fill/pixel engines (clients 1..N-1) and GRAM.
//   Client 0 gets strict priority while en_fetching is high; all other arbitration is round-robin.
//   Clients may read or write. Read data is broadcast to all clients with a one-hot transfer tag.
// PARAMETERS
//   NUM_CLIENTS  4   number of requesters, 2..8; client 0 is the fetch client
//   ADDR_W       17  memory word address width
//   DATA_W       32  memory data width
//   RD_LAT       1   BRAM read latency in cycles (address presented -> mem_data_in valid), 1..3
//   PRIO_FETCH   1   1: client 0 has strict priority while en_fetching=1; 0: plain round-robin
// PORTS
//   clk          in   1               system clock (25 MHz pixel domain)
//   rst_         in   1               asynchronous active-low reset
//   en_fetching  in   1               refresh engine is in its fetch window
//   req_rts      in   N               per-client request valid
//   req_rtr      out  N               per-client grant, one-hot or zero
//   req_addr     in   N*ADDR_W        per-client address; client i uses [i*ADDR_W +: ADDR_W]
//   req_wrdata   in   N*DATA_W        per-client write data
//   req_wben     in   N*4             per-client byte enables; 4'b0000 = read, nonzero = write
//   mem_addr     out  ADDR_W          registered BRAM address
//   mem_data_out out  DATA_W          registered BRAM write data
//   mem_wben     out  4               registered BRAM byte write enables
//   mem_data_in  in   DATA_W          BRAM read data
//   bcast_data   out  DATA_W          registered read data, broadcast to all clients
//   bcast_xfc    out  N               one-hot: bcast_data belongs to client i this cycle
// BEHAVIOUR
//   - Reset: req_rtr, mem_addr, mem_data_out, mem_wben, bcast_data and bcast_xfc are 0.
//     rr_ptr = N-1, so client 0 wins the first round-robin pass. All read-tag pipeline stages
//     are cleared. Reset asserted mid-operation drops in-flight reads: no bcast_xfc for them.
//   - Grant is combinational from req_rts, en_fetching and rr_ptr:
//       if PRIO_FETCH && en_fetching && req_rts[0], grant client 0;
//       else grant the first requester scanning rr_ptr+1, rr_ptr+2, ... with wrap N-1 -> 0.
//     req_rtr = grant, at most one bit set. Transfer (xfc) = req_rts[i] & req_rtr[i].
//   - rr_ptr <= granted index on every xfc, priority grants included. It holds when idle.
//   - One transfer per cycle at most. Back-to-back transfers are supported at full rate.
//   - Xfc at cycle T: mem_addr, mem_data_out and mem_wben take the client's values at T+1.
//     With no xfc, mem_wben = 0 at T+1 and mem_addr/mem_data_out hold their previous values.
//   - Read (wben=0) xfc at T: a one-hot tag travels through 1+RD_LAT register stages.
//     At T+2+RD_LAT, bcast_data = mem_data_in registered and bcast_xfc = tag for one cycle.
//     With RD_LAT=1 the latency is 3 cycles.
//   - Writes produce no bcast_xfc. bcast_xfc is 0 whenever no read completes.
//     bcast_data holds its last value.
//   - No requesters: req_rtr = 0 and rr_ptr is unchanged.
//   - A client that drops rts before it is granted is simply skipped. No state is kept per client.
//   - en_fetching=0: client 0 competes in round-robin like any other client.
//   - Requests are in order by construction, so broadcast order equals grant order.
// TESTING
//   1. Reset: rst_=0 with all rts=1 -> all outputs 0.
//      After release, first grant is client 0, then 1, 2, 3, 0 with all rts held high.
//   2. Single read: client 2 rts, addr=0x00010, wben=0 at T.
//      -> mem_addr=0x00010 at T+1; bcast_xfc=4'b0100 at T+3 with mem contents (RD_LAT=1).
//   3. Priority: en_fetching=1 and rts=4'b1111 for 6 cycles -> client 0 granted every cycle.
//      After en_fetching drops, grants go 1, 2, 3, 0.
//   4. Write: client 1, addr=0x1FFFF, data=0xDEADBEEF, wben=4'hF.
//      -> mem_wben=4'hF at T+1, no bcast_xfc; a later read of 0x1FFFF broadcasts 0xDEADBEEF.
//   5. Pipelined reads: clients 0, 1, 3 read on consecutive cycles.
//      -> bcast_xfc = 0001, 0010, 1000 on three consecutive cycles.
//      With RD_LAT=2 the same sequence arrives one cycle later.
//   6. Reset mid-flight: assert rst_ one cycle after a read xfc -> no bcast_xfc pulse after release.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter in front of the single-port graphics BRAM. Client 0 can be
// given strict priority during the fetch window. Read data is broadcast with a one-hot tag.
module mem_arbiter_rr #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned PRIO_FETCH  = 1
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic                          en_fetching,
  input  logic [NUM_CLIENTS-1:0]        req_rts,
  output logic [NUM_CLIENTS-1:0]        req_rtr,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] req_wrdata,
  input  logic [NUM_CLIENTS*4-1:0]      req_wben,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_data_out,
  output logic [3:0]                    mem_wben,
  input  logic [DATA_W-1:0]             mem_data_in,
  output logic [DATA_W-1:0]             bcast_data,
  output logic [NUM_CLIENTS-1:0]        bcast_xfc
);

  localparam int unsigned IdxW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]        grant_idx;
  logic [NUM_CLIENTS-1:0] grant;
  logic                   xfc;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_data;
  logic [3:0]             sel_wben;
  logic                   sel_read;
  int unsigned            cand;

  // Stage 0 lines up with mem_addr; stage RD_LAT lines up with valid mem_data_in.
  logic [NUM_CLIENTS-1:0] tag_q [RD_LAT+1];

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    xfc       = 1'b0;
    cand      = 0;
    if (PRIO_FETCH != 0 && en_fetching && req_rts[0]) begin
      grant[0] = 1'b1;
      xfc      = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
        cand = (int'(rr_ptr_q) + k) % NUM_CLIENTS;
        if (!xfc && req_rts[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = IdxW'(cand);
          xfc         = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = xfc ? grant_idx : rr_ptr_q;
    sel_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
    sel_data = req_wrdata[grant_idx*DATA_W +: DATA_W];
    sel_wben = req_wben[grant_idx*4 +: 4];
    sel_read = xfc && (sel_wben == 4'b0000);
  end

  // Grant is combinational; hold it off while reset is asserted.
  assign req_rtr = rst_ ? grant : '0;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rr_ptr_q     <= IdxW'(NUM_CLIENTS - 1);
      mem_addr     <= '0;
      mem_data_out <= '0;
      mem_wben     <= '0;
      bcast_data   <= '0;
      bcast_xfc    <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (xfc) begin
        mem_addr     <= sel_addr;
        mem_data_out <= sel_data;
        mem_wben     <= sel_wben;
      end else begin
        mem_wben <= '0;
      end
      tag_q[0] <= sel_read ? grant : '0;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      bcast_xfc <= tag_q[RD_LAT];
      if (|tag_q[RD_LAT]) begin
        bcast_data <= mem_data_in;
      end
    end
  end

endmodule
